// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for mem_port_arb: FSM state encoding, address/data width,
// default starvation limit and the load-alignment helper.
package mem_port_arb_pkg;

   localparam int SIZE_ADDR        = 48;
   localparam int STARVE_LIMIT_DEF = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_ADDR = 2'd2;
   localparam logic [1:0] ST_DATA = 2'd3;

   // 24-bit loads return the low half of the word, zero-extended.
   function automatic logic [SIZE_ADDR-1:0] load_align(input logic [SIZE_ADDR-1:0] word,
                                                       input logic                 is48);
      return is48 ? word : {24'd0, word[23:0]};
   endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Two-port memory arbiter: slots an external request into the MA stage's port schedule.
// Optional starvation relief (forced MA bubble after STARVE_LIMIT waits) under `MEM_ARB_STARVE_EN.
module mem_port_arb
   import mem_port_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   output logic                 ow_mem_mp,
   input  logic                 iw_ma_mem_use,
   output logic                 ow_stall_ma,
   input  logic                 iw_ext_valid,
   output logic                 ow_ext_ready,
   input  logic                 iw_ext_we,
   input  logic                 iw_ext_is48,
   input  logic [SIZE_ADDR-1:0] iw_ext_addr,
   input  logic [SIZE_ADDR-1:0] iw_ext_wdata,
   output logic                 ow_ext_rvalid,
   output logic [SIZE_ADDR-1:0] ow_ext_rdata,
   output logic                 ow_xa_en,
   output logic                 ow_xa_port,
   output logic [SIZE_ADDR-1:0] ow_xa_addr,
   output logic                 ow_xd_en,
   output logic                 ow_xd_we,
   output logic                 ow_xd_is48,
   output logic [SIZE_ADDR-1:0] ow_xd_wdata,
   input  logic [SIZE_ADDR-1:0] iw_mem_rdata0,
   input  logic [SIZE_ADDR-1:0] iw_mem_rdata1,
   output logic [1:0]           ow_dbg_state
);

   logic [1:0]           state;
   logic                 mp;
   logic                 port_q;
   logic                 we_q;
   logic                 is48_q;
   logic [SIZE_ADDR-1:0] addr_q;
   logic [SIZE_ADDR-1:0] wdata_q;
   logic                 rvalid_q;
   logic [SIZE_ADDR-1:0] rdata_q;
   logic                 slot_free;
   logic [SIZE_ADDR-1:0] rdata_sel;

`ifdef MEM_ARB_STARVE_EN
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic [7:0] wait_cnt;

   assign ow_stall_ma = (state == ST_PEND) && (wait_cnt == LIMIT);

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         wait_cnt <= '0;
      end else if (state == ST_IDLE && iw_ext_valid) begin
         wait_cnt <= '0;
      end else if (state == ST_PEND && !slot_free && wait_cnt != LIMIT) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end
`else
   // Relief compiled out; the parameter stays referenced so both builds share one interface.
   assign ow_stall_ma = (STARVE_LIMIT > 255) & 1'b0;
`endif

   // Ext handshake: a request transfers on a cycle where iw_ext_valid && ow_ext_ready;
   // ready is high only in IDLE, and the payload must hold steady while valid waits.
   assign ow_ext_ready = (state == ST_IDLE);
   assign slot_free    = !iw_ma_mem_use || ow_stall_ma;
   assign rdata_sel    = port_q ? iw_mem_rdata1 : iw_mem_rdata0;

   assign ow_mem_mp     = mp;
   assign ow_ext_rvalid = rvalid_q;
   assign ow_ext_rdata  = rdata_q;
   assign ow_xa_en      = (state == ST_ADDR);
   assign ow_xa_port    = port_q;
   assign ow_xa_addr    = addr_q;
   assign ow_xd_en      = (state == ST_DATA);
   assign ow_xd_we      = we_q;
   assign ow_xd_is48    = is48_q;
   assign ow_xd_wdata   = wdata_q;
   assign ow_dbg_state  = state;

   // port_q takes mp from the last PEND cycle: two toggles later DATA sees mp == port_q,
   // and in ADDR (one toggle later) the MA-side port !mp equals port_q as well.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state    <= ST_IDLE;
         mp       <= 1'b0;
         port_q   <= 1'b0;
         we_q     <= 1'b0;
         is48_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         mp       <= ~mp;
         rvalid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iw_ext_valid) begin
                  we_q    <= iw_ext_we;
                  is48_q  <= iw_ext_is48;
                  addr_q  <= iw_ext_addr;
                  wdata_q <= iw_ext_wdata;
                  state   <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (slot_free) begin
                  port_q <= mp;
                  state  <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               state <= ST_DATA;
            end
            default: begin
               if (!we_q) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= load_align(rdata_sel, is48_q);
               end
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
